// File: rtl/mas_pkg.sv
// mas_pkg: shared encodings and width helpers for the modular add/sub pipe.
// Provides sel/tcmp enums, default residue width and derived widths.
package mas_pkg;

  typedef enum logic [1:0] {
    SEL_ADD     = 2'b00,
    SEL_SUB     = 2'b01,
    SEL_ACC_ADD = 2'b10,
    SEL_ACC_SUB = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    TCMP_NONE = 2'b00,
    TCMP_SUBQ = 2'b01,
    TCMP_ADDQ = 2'b10
  } tcmp_e;

  localparam int W_DEF = 4;

  function automatic int raw_w(input int w);
    return w + 1;
  endfunction

  function automatic int ext_w(input int w);
    return w + 2;
  endfunction

  function automatic logic is_acc(input sel_e s);
    return s[1];
  endfunction

  function automatic logic is_sub(input sel_e s);
    return s[0];
  endfunction

endpackage

// File: rtl/mas_pipe_mod_reduce.sv
// mod_reduce: one-step modular correction of a raw S1 result.
// Ports: raw (W+1), sub, q -> corr (W), tcmp.
module mod_reduce
  import mas_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W:0]   raw,
  input  logic         sub,
  input  logic [W-1:0] q,
  output logic [W-1:0] corr,
  output tcmp_e        tcmp
);

  localparam int EW = ext_w(W);

  logic signed [EW-1:0] rx;
  logic signed [EW-1:0] qx;

  // An add of two residues is never negative and a sub never reaches
  // 2^W, so the op type tells how to widen the W+1 bit raw value.
  always_comb begin
    rx   = sub ? $signed({raw[W], raw})
               : $signed({1'b0, raw});
    qx   = $signed({2'b00, q});
    corr = raw[W-1:0];
    tcmp = TCMP_NONE;
    unique case (1'b1)
      rx[EW-1]: begin
        corr = raw[W-1:0] + q;
        tcmp = TCMP_ADDQ;
      end
      (rx >= qx): begin
        corr = raw[W-1:0] - q;
        tcmp = TCMP_SUBQ;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mas_pipe.sv
// mas_pipe: 2-stage (a +/- b) mod q with accumulator and valid/ready.
// in: in_valid/din1/din2/sel/q/acc_clr, out: out_valid/dout/tdout/tcmp.
module mas_pipe
  import mas_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] din1,
  input  logic [W-1:0] din2,
  input  logic [1:0]   sel,
  input  logic [W-1:0] q,
  input  logic         acc_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dout,
  output logic [W:0]   tdout,
  output logic [1:0]   tcmp
);

  sel_e         op;
  sel_e         s1_sel;
  logic         s1_valid;
  logic [W:0]   s1_raw;
  logic [W-1:0] s1_q;
  logic         s1_sub;
  logic         s2_adv;
  logic         s1_adv;
  logic [W-1:0] corr;
  tcmp_e        corr_tcmp;
  logic [W-1:0] acc;
  logic [W-1:0] x_op;
  logic [W-1:0] y_op;
  logic [W:0]   raw_nxt;

  assign op       = sel_e'(sel);
  assign s1_sub   = is_sub(s1_sel);
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;

  mod_reduce #(
    .W(W)
  ) u_reduce (
    .raw (s1_raw),
    .sub (s1_sub),
    .q   (s1_q),
    .corr(corr),
    .tcmp(corr_tcmp)
  );

  // Accumulator operand: a pending acc op in S1 has not reached acc
  // yet, so its corrected value is forwarded to avoid a bubble.
  always_comb begin
    x_op = din1;
    y_op = din2;
    if (is_acc(op)) begin
      y_op = din1;
      if (acc_clr)
        x_op = '0;
      else if (s1_valid && is_acc(s1_sel))
        x_op = corr;
      else
        x_op = acc;
    end
  end

  // Low W+1 bits of the W+2 bit sum; mod_reduce restores the sign.
  always_comb begin
    if (is_sub(op))
      raw_nxt = {1'b0, x_op} - {1'b0, y_op};
    else
      raw_nxt = {1'b0, x_op} + {1'b0, y_op};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_raw   <= '0;
      s1_q     <= '0;
      s1_sel   <= SEL_ADD;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_raw <= raw_nxt;
        s1_q   <= q;
        s1_sel <= op;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
      tdout     <= '0;
      tcmp      <= TCMP_NONE;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        dout  <= corr;
        tdout <= s1_raw;
        tcmp  <= corr_tcmp;
      end
    end
  end

  // Clear wins over a same-cycle write from a retiring acc op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (acc_clr)
      acc <= '0;
    else if (s1_adv && is_acc(s1_sel))
      acc <= corr;
  end

endmodule

// File: tb/tb_mas_pipe.sv
// tb_mas_pipe: directed table plus hand sequences for mas_pipe (W=4).
// Covers reset, corrections, forwarding, acc_clr, stall, mid-flight reset.
module tb_mas_pipe;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] din1;
  logic [W-1:0] din2;
  logic [1:0]   sel;
  logic [W-1:0] q;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] dout;
  logic [W:0]   tdout;
  logic [1:0]   tcmp;

  int n_chk;
  int n_fail;

  mas_pipe #(
    .W(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din1     (din1),
    .din2     (din2),
    .sel      (sel),
    .q        (q),
    .acc_clr  (acc_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout),
    .tdout    (tdout),
    .tcmp     (tcmp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W:0]   tdout;
    logic [1:0]   tcmp;
    logic [W-1:0] dout;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic put(input logic [1:0] s, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] qq);
    in_valid = 1'b1;
    sel      = s;
    din1     = a;
    din2     = b;
    q        = qq;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    acc_clr = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    din1      = '0;
    din2      = '0;
    sel       = 2'b00;
    q         = 4'd13;
    acc_clr   = 1'b0;
    out_ready = 1'b1;

    // sel, a, b, q, raw (5-bit pattern), tcmp, dout
    vecs[0] = '{2'b00, 4'd9,  4'd7,  4'd13, 5'd16, 2'b01, 4'd3};
    vecs[1] = '{2'b01, 4'd2,  4'd9,  4'd13, 5'd25, 2'b10, 4'd6};
    vecs[2] = '{2'b00, 4'd3,  4'd4,  4'd13, 5'd7,  2'b00, 4'd7};
    vecs[3] = '{2'b01, 4'd9,  4'd9,  4'd13, 5'd0,  2'b00, 4'd0};
    vecs[4] = '{2'b00, 4'd14, 4'd14, 4'd15, 5'd28, 2'b01, 4'd13};
    vecs[5] = '{2'b01, 4'd0,  4'd14, 4'd15, 5'd18, 2'b10, 4'd1};
    vecs[6] = '{2'b00, 4'd1,  4'd1,  4'd2,  5'd2,  2'b01, 4'd0};
    vecs[7] = '{2'b00, 4'd12, 4'd0,  4'd13, 5'd12, 2'b00, 4'd12};
    vecs[8] = '{2'b00, 4'd6,  4'd7,  4'd13, 5'd13, 2'b01, 4'd0};
    vecs[9] = '{2'b01, 4'd0,  4'd1,  4'd7,  5'd31, 2'b10, 4'd6};

    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_dout", dout, 0);
    check("rst_tdout", tdout, 0);
    check("rst_tcmp", tcmp, 0);
    check("rst_acc", dut.acc, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      put(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].q);
      #1 check($sformatf("v%0d_in_ready", i), in_ready, 1);
      @(negedge clk);
      idle();
      check($sformatf("v%0d_lat1_valid", i), out_valid, 0);
      @(negedge clk);
      check($sformatf("v%0d_out_valid", i), out_valid, 1);
      check($sformatf("v%0d_tdout", i), tdout, vecs[i].tdout);
      check($sformatf("v%0d_tcmp", i), tcmp, vecs[i].tcmp);
      check($sformatf("v%0d_dout", i), dout, vecs[i].dout);
    end

    // back-to-back accumulator ops with forwarding
    @(negedge clk);
    do_reset();
    put(2'b10, 4'd12, 4'd0, 4'd13);
    @(negedge clk);
    put(2'b10, 4'd5, 4'd0, 4'd13);
    @(negedge clk);
    check("fwd0_valid", out_valid, 1);
    check("fwd0_dout", dout, 12);
    put(2'b11, 4'd9, 4'd0, 4'd13);
    @(negedge clk);
    check("fwd1_valid", out_valid, 1);
    check("fwd1_dout", dout, 4);
    check("fwd1_tcmp", tcmp, 1);
    idle();
    @(negedge clk);
    check("fwd2_valid", out_valid, 1);
    check("fwd2_dout", dout, 8);
    check("fwd2_tdout", tdout, 27);
    check("fwd2_tcmp", tcmp, 2);
    check("fwd_acc", dut.acc, 8);

    // acc_clr while an acc op sits in S1
    do_reset();
    put(2'b10, 4'd12, 4'd0, 4'd13);
    @(negedge clk);
    acc_clr = 1'b1;
    put(2'b10, 4'd5, 4'd0, 4'd13);
    @(negedge clk);
    acc_clr = 1'b0;
    idle();
    check("clr_valid", out_valid, 1);
    check("clr_dout", dout, 12);
    check("clr_acc", dut.acc, 0);
    @(negedge clk);
    check("clr_next_dout", dout, 5);
    check("clr_next_acc", dut.acc, 5);

    // output stall: in_ready drops after two accepts
    do_reset();
    out_ready = 1'b0;
    put(2'b00, 4'd9, 4'd7, 4'd13);
    #1 check("stall_rdy0", in_ready, 1);
    @(negedge clk);
    put(2'b01, 4'd2, 4'd9, 4'd13);
    check("stall_rdy1", in_ready, 1);
    @(negedge clk);
    put(2'b00, 4'd3, 4'd4, 4'd13);
    #1 check("stall_rdy2", in_ready, 0);
    check("stall_valid2", out_valid, 1);
    check("stall_dout2", dout, 3);
    @(negedge clk);
    check("stall_rdy3", in_ready, 0);
    check("stall_dout3", dout, 3);
    check("stall_tdout3", tdout, 16);
    @(negedge clk);
    check("stall_dout4", dout, 3);
    check("stall_tcmp4", tcmp, 1);
    out_ready = 1'b1;
    #1 check("stall_rdy_release", in_ready, 1);
    @(negedge clk);
    idle();
    check("drain1_valid", out_valid, 1);
    check("drain1_dout", dout, 6);
    check("drain1_tcmp", tcmp, 2);
    @(negedge clk);
    check("drain2_valid", out_valid, 1);
    check("drain2_dout", dout, 7);
    @(negedge clk);
    check("drain_empty", out_valid, 0);

    // reset with two acc ops in flight
    do_reset();
    put(2'b10, 4'd12, 4'd0, 4'd13);
    @(negedge clk);
    put(2'b10, 4'd5, 4'd0, 4'd13);
    @(negedge clk);
    idle();
    check("mid_valid_before", out_valid, 1);
    check("mid_acc_before", dut.acc, 12);
    #1 rst = 1'b1;
    #1 check("mid_valid_rst", out_valid, 0);
    check("mid_rdy_rst", in_ready, 1);
    check("mid_dout_rst", dout, 0);
    check("mid_acc_rst", dut.acc, 0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int stale;
      stale = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (out_valid) stale++;
      end
      check("mid_no_stale", stale, 0);
    end
    check("mid_acc_after", dut.acc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
